// File: rtl/cpu_pkg.sv
// Definitions shared by the program loader and the CPU core.
// HALT_WORD is also decoded by the CPU as its halt instruction.
package cpu_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master side is the host plus memory; the slave side is the loader.
interface program_loader_if;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_address;
  logic [31:0] imem_write_data;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_address,
    input  imem_write_data
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_address,
    output imem_write_data
  );

endinterface

// File: rtl/program_loader_byte_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word.
// word_full flags the accept that fills the last lane.
module byte_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  index_q;
  logic [31:0] word_q;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      index_q <= '0;
      word_q  <= '0;
    end else if (byte_en) begin
      // Index wraps 3 -> 0 so the next word starts at lane 0.
      index_q                <= index_q + 2'd1;
      word_q[8*index_q +: 8] <= byte_data;
    end
  end

  assign word      = word_q;
  assign word_full = byte_en && (index_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot-time instruction memory writer: assembles bytes into words, writes them from
// address 0 up, and holds the CPU in reset until the halt word has been written.
module program_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  program_loader_if.slave       bus,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH:0] LastSlot = {1'b0, {ADDR_WIDTH{1'b1}}};

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  accept;
  logic                  clear;
  logic [31:0]           word;
  logic                  word_full;

  // byte_ready is decoded from state alone, so acceptance never depends on a comb path.
  assign accept = (state_q == RECV) && bus.byte_valid;
  assign clear  = (state_q == IDLE) && start;

  byte_assembler u_byte_assembler (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .byte_en   (accept),
    .byte_data (bus.byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          count_d = '0;
        end
      end
      RECV: begin
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        count_d = count_q + 1'b1;
        // Halt takes priority so a halt in the last slot still completes the load.
        if (word == HALT_WORD)      state_d = DONE;
        else if (count_q == LastSlot) state_d = ERROR;
        else                          state_d = RECV;
      end
      DONE, ERROR: ;
      default: state_d = IDLE;
    endcase
  end

  assign bus.byte_ready      = (state_q == RECV);
  assign bus.imem_we         = (state_q == WRITE);
  assign bus.imem_address    = 32'({count_q, 2'b00});
  assign bus.imem_write_data = word;
  assign cpu_reset           = (state_q != DONE);
  assign load_done           = (state_q == DONE);
  assign load_error          = (state_q == ERROR);
  assign word_count          = count_q;

endmodule
